product_accumulator: RTL

- Downstream stage of the 32x32 sequential multiplier.
- Consumes signed 64-bit products over a valid/ready handshake and sums a group of products, delimited by prod_last, into a wide internal accumulator.
- Delivers one saturated 64-bit dot-product result per group, plus the group's term count and a saturation flag, over a second valid/ready handshake.
- Used to build multiply-accumulate and dot-product datapaths around the multiplier.

---
 rtl/product_accumulator_pkg.sv | 19 +
 rtl/product_accumulator_sat_clip.sv | 24 ++
 rtl/product_accumulator.sv | 103 ++++++++++
 3 files changed

// File: rtl/product_accumulator_pkg.sv
// Shared widths, state encoding and signed limits for the product accumulator.
package product_accumulator_pkg;

    localparam int unsigned IN_W  = 64;
    localparam int unsigned ACC_W = 72;
    localparam int unsigned OUT_W = 64;
    localparam int unsigned CNT_W = 16;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

endpackage

// File: rtl/product_accumulator_sat_clip.sv
// Combinational signed clamp from IN to OUT bits; ovf_o flags a clamped value.
module product_accumulator_sat_clip #(
    parameter int unsigned IN  = 73,
    parameter int unsigned OUT = 72
) (
    input  logic [IN-1:0]  din_i,
    output logic [OUT-1:0] dout_o,
    output logic           ovf_o
);

    if (IN > OUT) begin : g_clip
        // The value fits only when every bit from the sign down to OUT-1 agrees.
        logic [IN-OUT:0] top_bits;
        assign top_bits = din_i[IN-1:OUT-1];
        assign ovf_o    = !((&top_bits) || !(|top_bits));
        assign dout_o   = !ovf_o      ? din_i[OUT-1:0] :
                          din_i[IN-1] ? {1'b1, {(OUT-1){1'b0}}} :
                                        {1'b0, {(OUT-1){1'b1}}};
    end else begin : g_pass
        assign dout_o = OUT'($signed(din_i));
        assign ovf_o  = 1'b0;
    end

endmodule

// File: rtl/product_accumulator.sv
// Sums groups of signed products delimited by prod_last and hands out one
// saturated result per group over a valid/ready handshake.
module product_accumulator #(
    parameter int unsigned IN_W  = product_accumulator_pkg::IN_W,
    parameter int unsigned ACC_W = product_accumulator_pkg::ACC_W,
    parameter int unsigned OUT_W = product_accumulator_pkg::OUT_W,
    parameter int unsigned CNT_W = product_accumulator_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             prod_valid,
    input  logic [IN_W-1:0]  prod,
    input  logic             prod_last,
    output logic             prod_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [OUT_W-1:0] res_data,
    output logic [CNT_W-1:0] res_count,
    output logic             res_sat
);

    import product_accumulator_pkg::state_e;
    import product_accumulator_pkg::ACCUM;
    import product_accumulator_pkg::HOLD;

    state_e             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   count_q;
    logic               sticky_q;
    logic [OUT_W-1:0]   res_data_q;
    logic [CNT_W-1:0]   res_count_q;
    logic               res_sat_q;

    logic [ACC_W:0]     sum_wide;
    logic [ACC_W-1:0]   acc_d;
    logic [CNT_W-1:0]   count_d;
    logic               sticky_d;
    logic               add_ovf;
    logic [OUT_W-1:0]   out_val;
    logic               clip_ovf;
    logic               accept;
    logic               take;

    // acc_q, count_q and sticky_q are already zero in HOLD, so a product taken
    // there naturally starts the next group.
    assign sum_wide = (ACC_W+1)'($signed(acc_q)) + (ACC_W+1)'($signed(prod));
    assign count_d  = (&count_q) ? count_q : count_q + CNT_W'(1);
    assign sticky_d = sticky_q | add_ovf;

    product_accumulator_sat_clip #(.IN(ACC_W+1), .OUT(ACC_W)) u_add_sat (
        .din_i  (sum_wide),
        .dout_o (acc_d),
        .ovf_o  (add_ovf)
    );

    product_accumulator_sat_clip #(.IN(ACC_W), .OUT(OUT_W)) u_out_clip (
        .din_i  (acc_d),
        .dout_o (out_val),
        .ovf_o  (clip_ovf)
    );

    assign prod_ready = (state_q == ACCUM) || res_ready;
    assign accept     = prod_valid && prod_ready;
    assign take       = (state_q == HOLD) && res_ready;

    assign res_valid  = (state_q == HOLD);
    assign res_data   = res_data_q;
    assign res_count  = res_count_q;
    assign res_sat    = res_sat_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            count_q     <= '0;
            sticky_q    <= 1'b0;
            res_data_q  <= '0;
            res_count_q <= '0;
            res_sat_q   <= 1'b0;
        end else begin
            if (take) begin
                state_q <= ACCUM;
            end
            // A last product reloads the result even while the old one leaves.
            if (accept) begin
                if (prod_last) begin
                    res_data_q  <= out_val;
                    res_count_q <= count_d;
                    res_sat_q   <= sticky_d | clip_ovf;
                    acc_q       <= '0;
                    count_q     <= '0;
                    sticky_q    <= 1'b0;
                    state_q     <= HOLD;
                end else begin
                    acc_q    <= acc_d;
                    count_q  <= count_d;
                    sticky_q <= sticky_d;
                end
            end
        end
    end

endmodule
